prio_arbiter: RTL and testbench
===============================

// Module: prio_arbiter
// PURPOSE
//  Parametrised registered priority encoder/arbiter; successor to the 4-input OR block.
//  Takes N request lines and produces a combinational any-request flag (N-wide OR).
//  Registers a winner index plus one-hot grant and holds it until acknowledged.
//  Selection is fixed-priority or round-robin, set by parameter.
//  Sits between N requesters and one shared resource (bus or register port).
// PARAMETERS
//  N      4   number of request lines; legal range 2..32
//  RR     0   0 = fixed priority, bit 0 highest; 1 = round-robin
//  IDX_W  $clog2(N)   localparam: width of idx
// PORTS
//  clk    in   1      single clock; all state updates on posedge
//  rst    in   1      asynchronous reset, active-high
//  req    in   N      request lines, level-sensitive, one per requester
//  ack    in   1      resource consumed current grant; sampled only when valid=1
//  any    out  1      combinational |req; no register, no reset dependency
//  valid  out  1      registered: a grant is held
//  idx    out  IDX_W  registered: index of granted requester; 0 when valid=0
//  grant  out  N      registered one-hot of idx when valid=1; all-zero otherwise
// BEHAVIOUR
//  Reset (async, while rst=1):
//   - valid=0, idx=0, grant=0, state=IDLE, RR pointer ptr=0.
//   - Takes effect immediately, including mid-grant.
//   - First possible grant is the first posedge after rst falls.
//  States:
//   - IDLE: valid=0. At posedge, if |req: pick winner w, latch idx=w and grant=1<<w,
//     go to GRANT. Latency is 1 clk from req to valid. If no req, stay in IDLE.
//   - GRANT: valid=1; idx and grant are stable and ignore other req changes.
//     - At posedge with ack=1: go to IDLE. idx and grant clear to 0. In RR mode,
//       ptr = (idx+1) mod N.
//     - At posedge with ack=0 and req[idx]=0: abort, go to IDLE, ptr unchanged.
//     - If ack=1 and req[idx]=0 in the same cycle: ack wins and ptr updates.
//     - Otherwise stay in GRANT.
//  After every release there is exactly one IDLE bubble cycle; no back-to-back grants.
//  Winner selection:
//   - Fixed: lowest set index of req.
//   - RR: first set index scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
//     Wrap-around is mod N, including when N is not a power of 2.
//  ack while valid=0 is ignored. X/Z on req has no defined behaviour.
//  idx never holds a value >= N. grant is always zero-hot or one-hot.
// TESTING
//  1. Reset, then any req set -> valid=0, idx=0, grant=0 until the first posedge after rst falls.
//  2. Fixed N=4: req=4'b1010 -> next clk valid=1, idx=1, grant=4'b0010.
//     Then req=4'b1000 with ack=0 -> abort, valid=0.
//  3. Fixed: req held 4'b0110, ack pulsed each grant -> idx=1 every time (starvation of bit 2 is expected).
//  4. RR N=4: req held 4'b1111, ack pulsed on every grant -> idx 0,1,2,3,0, each separated by one IDLE cycle.
//  5. RR N=3: grant idx 2, ack (ptr wraps to 0); then req=3'b101 -> idx 0.
//  6. Hold valid=1, idx=2, assert rst mid-cycle -> valid=0, grant=0 immediately, not at clk.
//     With req=0, any=0; with req=4'b0100, any=1 combinationally, before any clk edge.

Source files
------------

// File: rtl/prio_arbiter.sv
// -----------------------------------------------------------------------------
// prio_arbiter
//
// Registered priority arbiter for N requesters sharing one resource.
// Requests are level-sensitive. In IDLE a winner is picked, and its index and
// one-hot grant are latched one clock later. The grant is held until the
// resource acknowledges it, or until the winner drops its request (abort).
// Every release is followed by one IDLE bubble cycle, so two grants are never
// back-to-back.
//
// Winner selection:
//   RR = 0 : fixed priority, lowest set request index wins.
//   RR = 1 : round-robin. The scan starts at ptr and wraps mod N. ptr moves
//            to (idx+1) mod N only on an acknowledged grant. An abort leaves
//            ptr unchanged.
//
// Parameters:
//   N      number of request lines (2..32)
//   RR     0 = fixed priority, 1 = round-robin
//   IDX_W  width of idx, $clog2(N)
//
// Ports:
//   clk    clock, all state updates on posedge
//   rst    asynchronous reset, active-high
//   req    [N]     request lines
//   ack    1       resource consumed the current grant (ignored when valid=0)
//   any    1       combinational OR of req
//   valid  1       registered, a grant is held
//   idx    [IDX_W] registered index of the granted requester, 0 when idle
//   grant  [N]     registered one-hot of idx, all-zero when idle
// -----------------------------------------------------------------------------
module prio_arbiter #(
    parameter  int N     = 4,
    parameter  int RR    = 0,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             ack,
    output logic             any,
    output logic             valid,
    output logic [IDX_W-1:0] idx,
    output logic [N-1:0]     grant
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_ptr;
    logic [N-1:0]     r_grant;

    logic [IDX_W-1:0] w_ptr_nxt;
    logic [IDX_W-1:0] w_start;
    logic [IDX_W-1:0] w_win;
    logic [N-1:0]     w_win_onehot;
    logic [2*N-1:0]   w_req2;
    logic [N-1:0]     w_rot;
    logic             w_found;
    logic             w_load;
    logic             w_release;
    int               w_off;
    int               w_sum;

    // The any flag is intentionally unregistered and independent of reset.
    assign any = |req;

    // -------------------------------------------------------------------------
    // Winner selection.
    // The request vector is rotated so that the scan start sits at bit 0.
    // Then the lowest set bit of the rotated vector is found.
    // The offset is added back to the start position, wrapping mod N.
    // Doubling req makes the rotation a plain right shift. The same
    // wrap-around therefore works when N is not a power of two.
    // Fixed priority is the round-robin scan with the start pinned at 0.
    // -------------------------------------------------------------------------
    assign w_start = (RR != 0) ? r_ptr : '0;
    assign w_req2  = {req, req};
    assign w_rot   = N'(w_req2 >> w_start);

    always_comb begin
        // NOTE: every signal written here gets a default before any branch,
        // so no path can leave it unassigned and infer a latch.
        w_found = 1'b0;
        w_off   = 0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_off   = k;
            end
        end
        w_sum = int'(w_start) + w_off;
        if (w_sum >= N) begin
            w_sum = w_sum - N;
        end
        w_win = IDX_W'(w_sum);
    end

    always_comb begin
        w_win_onehot        = '0;
        w_win_onehot[w_win] = 1'b1;
    end

    // -------------------------------------------------------------------------
    // Next-state logic.
    // ack takes priority over a dropped request. An acknowledged grant moves
    // the round-robin pointer even if the winner has already let go of req.
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_load      = 1'b0;
        w_release   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_state_nxt = S_GRANT;
                    w_load      = 1'b1;
                end
            end
            S_GRANT: begin
                if (ack) begin
                    w_state_nxt = S_IDLE;
                    w_release   = 1'b1;
                    if (RR != 0) begin
                        w_ptr_nxt = (r_idx == IDX_W'(N - 1)) ? '0 : r_idx + 1'b1;
                    end
                end else if (!req[r_idx]) begin
                    w_state_nxt = S_IDLE;
                    w_release   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and output registers.
    // Reset clears everything immediately, even in the middle of a grant.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state is updated with non-blocking assignments, so every
        // register here samples the values from before this edge.
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_grant <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            if (w_load) begin
                r_idx   <= w_win;
                r_grant <= w_win_onehot;
            end else if (w_release) begin
                r_idx   <= '0;
                r_grant <= '0;
            end
        end
    end

    assign valid = (r_state == S_GRANT);
    assign idx   = r_idx;
    assign grant = r_grant;

endmodule

// File: tb/tb_prio_arbiter.sv
// -----------------------------------------------------------------------------
// tb_prio_arbiter
//
// Three arbiter instances run from one clock and one reset:
//   u_fix : N=4, fixed priority
//   u_rr4 : N=4, round-robin
//   u_rr3 : N=3, round-robin (non power-of-two wrap)
// The stimulus pushes the expected winner index into a per-instance queue.
// A monitor pops that queue and compares idx and grant on each new grant.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_prio_arbiter;

    logic       clk = 1'b0;
    logic       rst;

    logic [3:0] req_f;
    logic       ack_f;
    logic       any_f, valid_f;
    logic [1:0] idx_f;
    logic [3:0] grant_f;

    logic [3:0] req_r4;
    logic       ack_r4;
    logic       any_r4, valid_r4;
    logic [1:0] idx_r4;
    logic [3:0] grant_r4;

    logic [2:0] req_r3;
    logic       ack_r3;
    logic       any_r3, valid_r3;
    logic [1:0] idx_r3;
    logic [2:0] grant_r3;

    int n_checks = 0;
    int n_fail   = 0;

    int q_f[$];
    int q_r4[$];
    int q_r3[$];

    logic prev_f  = 1'b0;
    logic prev_r4 = 1'b0;
    logic prev_r3 = 1'b0;
    int   e_f, e_r4, e_r3;

    always #10 clk = ~clk;

    prio_arbiter #(.N(4), .RR(0)) u_fix (
        .clk(clk), .rst(rst), .req(req_f), .ack(ack_f),
        .any(any_f), .valid(valid_f), .idx(idx_f), .grant(grant_f)
    );

    prio_arbiter #(.N(4), .RR(1)) u_rr4 (
        .clk(clk), .rst(rst), .req(req_r4), .ack(ack_r4),
        .any(any_r4), .valid(valid_r4), .idx(idx_r4), .grant(grant_r4)
    );

    prio_arbiter #(.N(3), .RR(1)) u_rr3 (
        .clk(clk), .rst(rst), .req(req_r3), .ack(ack_r3),
        .any(any_r3), .valid(valid_r3), .idx(idx_r3), .grant(grant_r3)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitors: one scoreboard pop per rising edge of valid.
    always @(negedge clk) begin
        if (valid_f && !prev_f) begin
            check("fix_grant_expected", int'(q_f.size() != 0), 1);
            if (q_f.size() != 0) begin
                e_f = q_f.pop_front();
                check("fix_idx", int'(idx_f), e_f);
                check("fix_grant", int'(grant_f), 1 << e_f);
            end
        end
        prev_f <= valid_f;
    end

    always @(negedge clk) begin
        if (valid_r4 && !prev_r4) begin
            check("rr4_grant_expected", int'(q_r4.size() != 0), 1);
            if (q_r4.size() != 0) begin
                e_r4 = q_r4.pop_front();
                check("rr4_idx", int'(idx_r4), e_r4);
                check("rr4_grant", int'(grant_r4), 1 << e_r4);
            end
        end
        prev_r4 <= valid_r4;
    end

    always @(negedge clk) begin
        if (valid_r3 && !prev_r3) begin
            check("rr3_grant_expected", int'(q_r3.size() != 0), 1);
            if (q_r3.size() != 0) begin
                e_r3 = q_r3.pop_front();
                check("rr3_idx", int'(idx_r3), e_r3);
                check("rr3_grant", int'(grant_r3), 1 << e_r3);
            end
        end
        prev_r3 <= valid_r3;
    end

    initial begin : stim
        int rr4_exp[5];
        rr4_exp = '{0, 1, 2, 3, 0};

        rst    = 1'b1;
        req_f  = '0; ack_f  = 1'b0;
        req_r4 = '0; ack_r4 = 1'b0;
        req_r3 = '0; ack_r3 = 1'b0;

        // 1. Requests during reset must not produce a grant.
        repeat (2) @(negedge clk);
        req_f = 4'b1111;
        repeat (2) @(negedge clk);
        check("rst_valid", int'(valid_f), 0);
        check("rst_idx", int'(idx_f), 0);
        check("rst_grant", int'(grant_f), 0);
        check("rst_any_set", int'(any_f), 1);
        check("rst_any_clr", int'(any_r4), 0);
        q_f.push_back(0);
        rst = 1'b0;
        #1;
        check("post_rst_no_grant_yet", int'(valid_f), 0);
        @(negedge clk);                           // grant idx 0 seen by monitor
        ack_f = 1'b1; req_f = 4'b0000;            // ack wins over dropped req
        @(negedge clk);
        check("ack_release_valid", int'(valid_f), 0);
        check("ack_release_idx", int'(idx_f), 0);
        check("ack_release_grant", int'(grant_f), 0);
        ack_f = 1'b0;

        // 2. Fixed: 1010 -> idx 1, then abort when req[1] drops.
        req_f = 4'b1010;
        q_f.push_back(1);
        @(negedge clk);
        req_f = 4'b1000;
        @(negedge clk);
        check("abort_valid", int'(valid_f), 0);
        check("abort_grant", int'(grant_f), 0);
        q_f.push_back(3);
        @(negedge clk);
        ack_f = 1'b1;
        @(negedge clk);
        check("idx3_release", int'(valid_f), 0);
        ack_f = 1'b0; req_f = 4'b0000;

        // 3. Fixed: 0110 held, idx 1 every time, one bubble between grants.
        for (int i = 0; i < 3; i++) begin
            q_f.push_back(1);
            req_f = 4'b0110;
            @(negedge clk);
            ack_f = 1'b1;
            @(negedge clk);
            check("fix_bubble", int'(valid_f), 0);
            ack_f = 1'b0;
        end
        req_f = 4'b0000;

        // 4. Round-robin N=4, all requesting: 0,1,2,3,0.
        for (int i = 0; i < 5; i++) begin
            q_r4.push_back(rr4_exp[i]);
            req_r4 = 4'b1111;
            @(negedge clk);
            ack_r4 = 1'b1;
            @(negedge clk);
            check("rr4_bubble", int'(valid_r4), 0);
            ack_r4 = 1'b0;
        end
        req_r4 = 4'b0000;

        // 5. Round-robin N=3: wrap, abort keeps ptr, ack-over-drop moves ptr.
        req_r3 = 3'b100; q_r3.push_back(2);           // ptr 0 -> idx 2
        @(negedge clk);
        ack_r3 = 1'b1;                                // ptr wraps to 0
        @(negedge clk);
        ack_r3 = 1'b0;
        req_r3 = 3'b101; q_r3.push_back(0);           // ptr 0 -> idx 0
        @(negedge clk);
        ack_r3 = 1'b1;                                // ptr -> 1
        @(negedge clk);
        ack_r3 = 1'b0;
        q_r3.push_back(2);                            // ptr 1, 101 -> idx 2
        @(negedge clk);
        req_r3 = 3'b001;                              // abort, ptr stays 1
        @(negedge clk);
        check("rr3_abort_valid", int'(valid_r3), 0);
        req_r3 = 3'b101; q_r3.push_back(2);           // still ptr 1 -> idx 2
        @(negedge clk);
        ack_r3 = 1'b1; req_r3 = 3'b000;               // ack wins, ptr -> 0
        @(negedge clk);
        check("rr3_ackdrop_valid", int'(valid_r3), 0);
        ack_r3 = 1'b0;
        req_r3 = 3'b011; q_r3.push_back(0);           // ptr 0 -> idx 0
        @(negedge clk);
        ack_r3 = 1'b1;
        @(negedge clk);
        ack_r3 = 1'b0; req_r3 = 3'b000;

        // 6. Asynchronous reset in the middle of a grant.
        req_f = 4'b0100; q_f.push_back(2);
        @(negedge clk);
        check("pre_rst_valid", int'(valid_f), 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", int'(valid_f), 0);
        check("async_rst_grant", int'(grant_f), 0);
        check("async_rst_idx", int'(idx_f), 0);
        req_f = 4'b0000;
        #1;
        check("async_any_clr", int'(any_f), 0);
        req_f = 4'b0100;
        #1;
        check("async_any_set", int'(any_f), 1);
        req_f = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_after_rst", int'(valid_f), 0);

        check("fix_queue_drained", q_f.size(), 0);
        check("rr4_queue_drained", q_r4.size(), 0);
        check("rr3_queue_drained", q_r3.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
